// File: rtl/uart_rx_deframer.sv
// Receive deframer for the UART transmitter's sendSig/bitstream pair; rebuilds LSB-first words.
// Optional INPUT_SYNC_EN macro adds a 2-flop synchronizer on bs_in and send_sig (+2 cycles latency).
module uart_rx_deframer #(
   parameter int PACKET_SIZE = 16,
   parameter int CYCLE_DIV   = 100,
   parameter int PROP_DELAY  = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   bs_in,
   input  logic                   send_sig,
   input  logic                   data_ack,
   output logic [PACKET_SIZE-1:0] data_out,
   output logic                   data_valid,
   output logic                   busy,
   output logic                   overrun
);
   localparam int TW = $clog2(CYCLE_DIV*(PROP_DELAY+1)) + 1;
   localparam int BW = $clog2(PACKET_SIZE+1);
   localparam logic [TW-1:0] HALF_TICK  = TW'(CYCLE_DIV/2);
   localparam logic [TW-1:0] LAST_TICK  = TW'(CYCLE_DIV-1);
   localparam logic [TW-1:0] DELAY_LAST = TW'((PROP_DELAY > 0) ? PROP_DELAY*CYCLE_DIV-1 : 0);
   localparam logic [BW-1:0] LAST_BIT   = BW'(PACKET_SIZE-1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DELAY = 2'd1;
   localparam logic [1:0] RECV  = 2'd2;

   logic bs_int;
   logic send_int;

`ifdef INPUT_SYNC_EN
   logic [1:0] bs_sync;
   logic [1:0] send_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bs_sync   <= 2'b00;
         send_sync <= 2'b00;
      end else begin
         bs_sync   <= {bs_sync[0], bs_in};
         send_sync <= {send_sync[0], send_sig};
      end
   end

   assign bs_int   = bs_sync[1];
   assign send_int = send_sync[1];
`else
   assign bs_int   = bs_in;
   assign send_int = send_sig;
`endif

   logic [1:0]             state;
   logic [TW-1:0]          tick;
   logic [BW-1:0]          bit_cnt;
   logic [PACKET_SIZE-1:0] shift;
   logic                   send_q;
   logic                   start;
   logic                   sample;
   logic                   last_sample;
   logic [PACKET_SIZE:0]   shift_ext;
   logic [PACKET_SIZE-1:0] shift_next;

   assign start       = (state == IDLE) && send_int && !send_q;
   assign sample      = (state == RECV) && (tick == HALF_TICK);
   assign last_sample = sample && (bit_cnt == LAST_BIT);
   assign shift_ext   = {bs_int, shift};
   assign shift_next  = shift_ext[PACKET_SIZE:1];
   assign busy        = (state != IDLE);

   // tick restarts at 1 on the cycle after the edge, so tick counts cycles since T0
   // in DELAY, and cycles since the start of the current bit period in RECV.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         tick    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         send_q  <= 1'b1;
      end else begin
         send_q <= send_int;
         case (state)
            IDLE: begin
               if (start) begin
                  bit_cnt <= '0;
                  tick    <= TW'(1);
                  state   <= (PROP_DELAY > 0) ? DELAY : RECV;
               end
            end
            DELAY: begin
               if (tick == DELAY_LAST) begin
                  tick  <= '0;
                  state <= RECV;
               end else begin
                  tick <= tick + 1'b1;
               end
            end
            RECV: begin
               tick <= (tick == LAST_TICK) ? '0 : tick + 1'b1;
               if (sample) begin
                  shift   <= shift_next;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (last_sample) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A load in the same cycle as data_ack takes priority over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (last_sample) begin
         data_out   <= shift_next;
         data_valid <= 1'b1;
         if (data_valid && !data_ack) begin
            overrun <= 1'b1;
         end
      end else if (data_ack) begin
         data_valid <= 1'b0;
      end
   end
endmodule
